modulo_arbitro_reservatorio_rolhas: RTL and testbench

Controller that owns the 7-bit cork reservoir count and arbitrates access to its single add/subtract update path. It serves three requesters: sealing consumption (one cork per sealed bottle), operator batch loading and automatic warehouse replenishment. It sits between the filling/sealing state machine, the operator's debounced inputs and the cork BCD display encoders. It replaces the ad-hoc mux/permission selection in front of the cork register with one sequenced, prioritised update per operation.

---
 rtl/modulo_arbitro_reservatorio_rolhas.sv | 126 ++++++++++++
 tb/tb_modulo_arbitro_reservatorio_rolhas.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_arbitro_reservatorio_rolhas.sv
// Cork reservoir owner: prioritised, one-update-per-operation arbiter for consumption, operator load and replenishment.
// Define REPOSICAO_AUTO_EN to build automatic warehouse replenishment; otherwise rep_gnt is tied low.
module modulo_arbitro_reservatorio_rolhas #(
    parameter int WIDTH          = 7,
    parameter int CAP_MAX        = 99,
    parameter int MIN_ROLHAS     = 5,
    parameter int LOTE_REPOSICAO = 20
) (
    input  logic             clk,
    input  logic             Nclr,
    input  logic             enable,
    input  logic             req_ve,
    input  logic             req_op,
    input  logic [WIDTH-1:0] op_qtd,
    input  logic             estoque_disp,
    output logic [WIDTH-1:0] rolhas,
    output logic             min_r,
    output logic             ve_gnt,
    output logic             op_gnt,
    output logic             rep_gnt,
    output logic             erro_falta,
    output logic             erro_excesso,
    output logic             ocupado
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CONSUMO   = 2'd1;
    localparam logic [1:0] S_CARGA_OP  = 2'd2;
    localparam logic [1:0] S_REPOSICAO = 2'd3;

    logic [1:0]       r_estado;
    logic             r_p_ve;
    logic             r_p_op;
    logic             r_p_rep;
    logic [WIDTH-1:0] r_qtd_op;
    logic [WIDTH-1:0] r_rolhas;

    logic             w_vazio;
    logic             w_rep_set;
    logic             w_soma_sat;
    logic [WIDTH-1:0] w_parcela;
    logic [WIDTH:0]   w_soma;

    assign w_vazio    = (r_rolhas == '0);
    assign min_r      = (r_rolhas < WIDTH'(MIN_ROLHAS));
    assign w_parcela  = (r_estado == S_REPOSICAO) ? WIDTH'(LOTE_REPOSICAO) : r_qtd_op;
    // One bit wider so the clip test sees the true sum before truncation.
    assign w_soma     = {1'b0, r_rolhas} + {1'b0, w_parcela};
    assign w_soma_sat = (w_soma > (WIDTH+1)'(CAP_MAX));

`ifdef REPOSICAO_AUTO_EN
    assign w_rep_set = min_r & estoque_disp & enable & ~r_p_rep & (r_estado != S_REPOSICAO);
    assign rep_gnt   = (r_estado == S_REPOSICAO);
`else
    // estoque_disp stays on the port for pin compatibility but has no effect here.
    assign w_rep_set = 1'b0 & estoque_disp;
    assign rep_gnt   = 1'b0;
`endif

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            r_p_ve  <= 1'b0;
            r_p_op  <= 1'b0;
            r_p_rep <= 1'b0;
        end else if (!enable) begin
            r_p_ve  <= 1'b0;
            r_p_op  <= 1'b0;
            r_p_rep <= 1'b0;
        end else begin
            if (r_estado == S_CONSUMO)        r_p_ve  <= 1'b0;
            else if (req_ve)                  r_p_ve  <= 1'b1;
            if (r_estado == S_CARGA_OP)       r_p_op  <= 1'b0;
            else if (req_op)                  r_p_op  <= 1'b1;
            if (r_estado == S_REPOSICAO)      r_p_rep <= 1'b0;
            else if (w_rep_set)               r_p_rep <= 1'b1;
        end
    end

    // Quantity is captured only when the operator request is accepted.
    always_ff @(posedge clk) begin
        if (enable && req_op && !r_p_op)
            r_qtd_op <= op_qtd;
    end

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            r_estado <= S_IDLE;
        end else begin
            case (r_estado)
                S_IDLE: begin
                    if (enable) begin
                        if (r_p_ve)       r_estado <= S_CONSUMO;
                        else if (r_p_rep) r_estado <= S_REPOSICAO;
                        else if (r_p_op)  r_estado <= S_CARGA_OP;
                    end
                end
                default: r_estado <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            r_rolhas <= '0;
        end else begin
            case (r_estado)
                S_CONSUMO: begin
                    if (!w_vazio)
                        r_rolhas <= r_rolhas - 1'b1;
                end
                S_CARGA_OP, S_REPOSICAO: begin
                    r_rolhas <= w_soma_sat ? WIDTH'(CAP_MAX) : w_soma[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign rolhas       = r_rolhas;
    assign ve_gnt       = (r_estado == S_CONSUMO) & ~w_vazio;
    assign erro_falta   = (r_estado == S_CONSUMO) & w_vazio;
    assign op_gnt       = (r_estado == S_CARGA_OP);
    assign erro_excesso = ((r_estado == S_CARGA_OP) | (r_estado == S_REPOSICAO)) & w_soma_sat;
    assign ocupado      = (r_estado != S_IDLE);

endmodule

// File: tb/tb_modulo_arbitro_reservatorio_rolhas.sv
// Bench for the cork reservoir arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_modulo_arbitro_reservatorio_rolhas;

`ifdef REPOSICAO_AUTO_EN
    localparam bit HAS_REP      = 1'b1;
    localparam int CNT_APOS_REP = 24;
`else
    localparam bit HAS_REP      = 1'b0;
    localparam int CNT_APOS_REP = 4;
`endif

    logic       clk = 1'b0;
    logic       Nclr;
    logic       enable;
    logic       req_ve;
    logic       req_op;
    logic [6:0] op_qtd;
    logic       estoque_disp;
    logic [6:0] rolhas;
    logic       min_r, ve_gnt, op_gnt, rep_gnt, erro_falta, erro_excesso, ocupado;

    int n_checks = 0;
    int n_err    = 0;

    modulo_arbitro_reservatorio_rolhas dut (
        .clk          (clk),
        .Nclr         (Nclr),
        .enable       (enable),
        .req_ve       (req_ve),
        .req_op       (req_op),
        .op_qtd       (op_qtd),
        .estoque_disp (estoque_disp),
        .rolhas       (rolhas),
        .min_r        (min_r),
        .ve_gnt       (ve_gnt),
        .op_gnt       (op_gnt),
        .rep_gnt      (rep_gnt),
        .erro_falta   (erro_falta),
        .erro_excesso (erro_excesso),
        .ocupado      (ocupado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nome, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", nome, act, exp, $time);
        end
    endtask

    // Model: a count, three one-deep request slots, and which operation is being served this cycle.
    localparam int SRV_NONE = 0, SRV_VE = 1, SRV_REP = 2, SRV_OP = 3;
    int m_cnt, m_srv, m_qtd, m_add, m_nsrv;
    bit m_pve, m_pop, m_prep, m_low;

    always @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            m_cnt = 0; m_srv = SRV_NONE; m_qtd = 0;
            m_pve = 0; m_pop = 0; m_prep = 0;
        end else begin
            m_low = (m_cnt < 5);
            if (m_srv == SRV_VE && m_cnt > 0) m_cnt = m_cnt - 1;
            if (m_srv == SRV_OP || m_srv == SRV_REP) begin
                m_add = (m_srv == SRV_OP) ? m_qtd : 20;
                m_cnt = (m_cnt + m_add > 99) ? 99 : m_cnt + m_add;
            end
            m_nsrv = SRV_NONE;
            if (m_srv == SRV_NONE && enable) begin
                if (m_pve)       m_nsrv = SRV_VE;
                else if (m_prep) m_nsrv = SRV_REP;
                else if (m_pop)  m_nsrv = SRV_OP;
            end
            if (!enable) begin
                m_pve = 0; m_pop = 0; m_prep = 0;
            end else begin
                if (!m_pop && req_op) m_qtd = int'(op_qtd);
                m_pve  = m_pve  ? (m_srv != SRV_VE)  : req_ve;
                m_pop  = m_pop  ? (m_srv != SRV_OP)  : req_op;
                m_prep = HAS_REP && (m_prep ? (m_srv != SRV_REP)
                                            : (m_low && estoque_disp && m_srv != SRV_REP));
            end
            m_srv = m_nsrv;
        end
    end

    always @(negedge clk) begin
        if (Nclr) begin
            chk("cmp_rolhas", int'(rolhas), m_cnt);
            chk("cmp_flags {ve,op,rep,falta,excesso,ocupado,min}",
                int'({ve_gnt, op_gnt, rep_gnt, erro_falta, erro_excesso, ocupado, min_r}),
                int'({(m_srv == SRV_VE && m_cnt > 0), (m_srv == SRV_OP), (m_srv == SRV_REP),
                      (m_srv == SRV_VE && m_cnt == 0),
                      ((m_srv == SRV_OP && m_cnt + m_qtd > 99) || (m_srv == SRV_REP && m_cnt + 20 > 99)),
                      (m_srv != SRV_NONE), (m_cnt < 5)}));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ve, input logic op, input int q);
        @(posedge clk);
        #1;
        req_ve = ve; req_op = op; op_qtd = 7'(q);
        @(posedge clk);
        #1;
        req_ve = 1'b0; req_op = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!ocupado) break;
            step();
        end
        chk("wait_idle_ocupado", int'(ocupado), 0);
    endtask

    initial begin
        Nclr = 1'b0; enable = 1'b0; req_ve = 1'b0; req_op = 1'b0;
        op_qtd = '0; estoque_disp = 1'b0;
        repeat (3) step();
        chk("reset_rolhas", int'(rolhas), 0);
        chk("reset_min_r", int'(min_r), 1);
        chk("reset_outs", int'({ve_gnt, op_gnt, rep_gnt, erro_falta, erro_excesso, ocupado}), 0);
        @(negedge clk);
        #1;
        Nclr = 1'b1; enable = 1'b1;

        // Operator load 30 from empty.
        pulse(1'b0, 1'b1, 30);
        step();
        chk("load30_op_gnt", int'(op_gnt), 1);
        step();
        chk("load30_rolhas", int'(rolhas), 30);
        chk("load30_min_r", int'(min_r), 0);

        // 30 + 60 = 90, then 90 + 20 clips at 99.
        pulse(1'b0, 1'b1, 60);
        repeat (2) step();
        chk("load60_rolhas", int'(rolhas), 90);
        pulse(1'b0, 1'b1, 20);
        step();
        chk("clip_op_gnt", int'(op_gnt), 1);
        chk("clip_excesso", int'(erro_excesso), 1);
        step();
        chk("clip_rolhas", int'(rolhas), 99);
        chk("clip_excesso_gone", int'(erro_excesso), 0);

        // Reset in the middle of CARGA_OP.
        pulse(1'b0, 1'b1, 5);
        step();
        chk("midreset_in_carga", int'(op_gnt), 1);
        #2;
        Nclr = 1'b0;
        #1;
        chk("midreset_rolhas", int'(rolhas), 0);
        chk("midreset_ocupado", int'(ocupado), 0);
        chk("midreset_op_gnt", int'(op_gnt), 0);
        @(negedge clk);
        #1;
        Nclr = 1'b1;
        repeat (4) step();
        chk("after_reset_rolhas", int'(rolhas), 0);

        // Consumption from empty.
        pulse(1'b1, 1'b0, 0);
        step();
        chk("empty_erro_falta", int'(erro_falta), 1);
        chk("empty_ve_gnt", int'(ve_gnt), 0);
        step();
        chk("empty_rolhas", int'(rolhas), 0);
        chk("empty_falta_gone", int'(erro_falta), 0);

        // Load 5, consume one, replenishment follows when built.
        pulse(1'b0, 1'b1, 5);
        repeat (2) step();
        chk("load5_rolhas", int'(rolhas), 5);
        estoque_disp = 1'b1;
        pulse(1'b1, 1'b0, 0);
        step();
        chk("ve_gnt_at_5", int'(ve_gnt), 1);
        step();
        chk("consume_rolhas", int'(rolhas), 4);
        chk("consume_min_r", int'(min_r), 1);
        repeat (2) step();
        chk("rep_gnt", int'(rep_gnt), int'(HAS_REP));
        step();
        chk("rep_rolhas", int'(rolhas), CNT_APOS_REP);
        estoque_disp = 1'b0;
        wait_idle();

        // Bring count to 40, then simultaneous consume + load 10.
        pulse(1'b0, 1'b1, 40 - CNT_APOS_REP);
        repeat (2) step();
        chk("set40_rolhas", int'(rolhas), 40);
        pulse(1'b1, 1'b1, 10);
        step();
        chk("both_ve_first", int'({ve_gnt, op_gnt}), 2);
        step();
        chk("both_rolhas39", int'(rolhas), 39);
        step();
        chk("both_op_second", int'({ve_gnt, op_gnt}), 1);
        step();
        chk("both_rolhas49", int'(rolhas), 49);

        // enable drops during CONSUMO: consume completes, pending load is discarded.
        pulse(1'b1, 1'b1, 3);
        step();
        enable = 1'b0;
        step();
        chk("disable_rolhas", int'(rolhas), 48);
        chk("disable_ocupado", int'(ocupado), 0);
        repeat (3) step();
        chk("disable_hold", int'(rolhas), 48);
        enable = 1'b1;

        // Second request while the slot is full is dropped.
        @(posedge clk);
        #1;
        req_op = 1'b1; op_qtd = 7'd1;
        step();
        op_qtd = 7'd7;
        step();
        req_op = 1'b0;
        step();
        chk("drop_rolhas", int'(rolhas), 49);
        repeat (3) step();
        chk("drop_hold", int'(rolhas), 49);

        // Requests while disabled are ignored.
        enable = 1'b0;
        pulse(1'b0, 1'b1, 5);
        repeat (3) step();
        chk("ignored_rolhas", int'(rolhas), 49);
        chk("ignored_ocupado", int'(ocupado), 0);
        enable = 1'b1;
        step();
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
